// File: rtl/mem_burst_master.sv
// mem_burst_master: read/write burst initiator for a single-port synchronous-read RAM.
// Ports:
//   clk, rst                                    clock and synchronous active-high reset
//   i_cmd_valid/o_cmd_ready, i_cmd_write,
//   i_cmd_adr, i_cmd_len                        burst command (len = beats - 1)
//   i_wr_valid/o_wr_ready, i_wr_data            write beat stream into the RAM
//   o_rd_valid/i_rd_ready, o_rd_data            read beat stream out of the RAM
//   o_busy, o_done                              burst in progress / end-of-burst pulse
//   o_adr, o_dat_w, o_we, i_dat_r               RAM port
module mem_burst_master #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_adr,
    input  logic [ADDR_W-1:0] i_cmd_len,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_adr,
    output logic [DATA_W-1:0] o_dat_w,
    output logic              o_we,
    input  logic [DATA_W-1:0] i_dat_r
);
    typedef enum logic [1:0] {IDLE, WR, RD_FILL, RD_DATA} state_t;
    state_t            r_state, w_state_n;
    logic [ADDR_W-1:0] r_cur, r_left, w_cur_n, w_left_n, w_cur_inc;
    logic              r_done, w_done_n, w_last, w_beat;
    assign w_cur_inc = r_cur + 1'b1;
    assign w_last    = r_left == '0;
    assign w_beat    = (r_state == WR && i_wr_valid) || (r_state == RD_DATA && i_rd_ready);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cur   <= '0;
            r_left  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cur   <= w_cur_n;
            r_left  <= w_left_n;
            r_done  <= w_done_n;
        end
    end
    always_comb begin
        w_state_n = r_state;
        w_cur_n   = r_cur;
        w_left_n  = r_left;
        w_done_n  = 1'b0;
        case (r_state)
            IDLE: if (i_cmd_valid) begin
                w_cur_n   = i_cmd_adr;
                w_left_n  = i_cmd_len;
                w_state_n = i_cmd_write ? WR : RD_FILL;
            end
            RD_FILL: w_state_n = RD_DATA;
            default: if (w_beat) begin
                if (w_last) begin
                    w_state_n = IDLE;
                    w_done_n  = 1'b1;
                end else begin
                    w_cur_n  = w_cur_inc;
                    w_left_n = r_left - 1'b1;
                end
            end
        endcase
    end
    assign o_cmd_ready = !rst && r_state == IDLE;
    assign o_wr_ready  = !rst && r_state == WR;
    assign o_we        = o_wr_ready && i_wr_valid;
    assign o_rd_valid  = !rst && r_state == RD_DATA;
    assign o_rd_data   = i_dat_r;
    assign o_busy      = !rst && r_state != IDLE;
    assign o_done      = !rst && r_done;
    assign o_dat_w     = i_wr_data;
    // Read-ahead: on an accepted non-final beat present the next address now so
    // the synchronous RAM has the following beat ready one cycle later.
    assign o_adr       = (r_state == RD_DATA && i_rd_ready && !w_last) ? w_cur_inc : r_cur;
endmodule

// File: tb/tb_mem_burst_master.sv
// tb_mem_burst_master: directed and randomized bursts checked against a shadow RAM model.
module tb_mem_burst_master;
    logic       clk = 1'b0, rst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [3:0] cmd_adr, cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic       busy, done, we;
    logic [3:0] adr;
    logic [7:0] dat_w, dat_r;
    logic [7:0] mem [16];
    logic [7:0] shadow [16];
    logic [7:0] q_data [$];
    int         q_gaps [$];
    int         checks = 0, failures = 0;

    mem_burst_master dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_adr(cmd_adr), .i_cmd_len(cmd_len),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
        .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data),
        .o_busy(busy), .o_done(done),
        .o_adr(adr), .o_dat_w(dat_w), .o_we(we), .i_dat_r(dat_r)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we) mem[adr] <= dat_w;
        dat_r <= mem[adr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a0, input logic [3:0] len,
                            input logic [7:0] data [$], input int gaps [$]);
        logic [3:0] a;
        int         ng;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_adr = a0; cmd_len = len;
        @(negedge clk);
        chk("wr_cmd_ready", cmd_ready, 1);
        chk("wr_idle_done", done, 0);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            a  = a0 + i[3:0];
            ng = i < gaps.size() ? gaps[i] : 0;
            for (int g = 0; g < ng; g++) begin
                wr_valid = 1'b0; wr_data = 8'($urandom);
                @(negedge clk);
                chk("wr_gap_ready", wr_ready, 1);
                chk("wr_gap_we", we, 0);
                chk("wr_gap_busy", busy, 1);
                chk("wr_gap_done", done, 0);
                step();
            end
            wr_valid = 1'b1; wr_data = data[i];
            @(negedge clk);
            chk("wr_we", we, 1);
            chk("wr_adr", adr, a);
            chk("wr_dat_w", dat_w, data[i]);
            chk("wr_busy_cmd_ready", cmd_ready, 0);
            chk("wr_rd_valid", rd_valid, 0);
            step();
            shadow[a] = data[i];
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("wr_done", done, 1);
        chk("wr_end_busy", busy, 0);
        chk("wr_end_cmd_ready", cmd_ready, 1);
        chk("wr_end_we", we, 0);
        step();
    endtask

    task automatic do_read(input logic [3:0] a0, input logic [3:0] len,
                           input int stall_beat, input int stall_n, input bit rnd);
        logic [3:0] a, an;
        int         n;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_adr = a0; cmd_len = len; rd_ready = 1'b0;
        @(negedge clk);
        chk("rd_cmd_ready", cmd_ready, 1);
        chk("rd_idle_done", done, 0);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rd_fill_valid", rd_valid, 0);
        chk("rd_fill_busy", busy, 1);
        chk("rd_fill_adr", adr, a0);
        chk("rd_fill_we", we, 0);
        step();
        for (int i = 0; i <= int'(len); i++) begin
            a  = a0 + i[3:0];
            an = a + 4'd1;
            n  = i == stall_beat ? stall_n : (rnd ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s < n; s++) begin
                rd_ready = 1'b0;
                @(negedge clk);
                chk("rd_stall_valid", rd_valid, 1);
                chk("rd_stall_data", rd_data, shadow[a]);
                chk("rd_stall_adr", adr, a);
                chk("rd_stall_done", done, 0);
                step();
            end
            rd_ready = 1'b1;
            @(negedge clk);
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, shadow[a]);
            chk("rd_adr", adr, i == int'(len) ? a : an);
            chk("rd_we", we, 0);
            step();
        end
        rd_ready = 1'b0;
        @(negedge clk);
        chk("rd_done", done, 1);
        chk("rd_end_valid", rd_valid, 0);
        chk("rd_end_busy", busy, 0);
        step();
    endtask

    initial begin
        logic [3:0] ra, rl;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_adr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_adr", adr, 0);
        step();

        q_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        q_gaps = {};
        do_write(4'd2, 4'd3, q_data, q_gaps);
        do_read(4'd2, 4'd3, -1, 0, 1'b0);
        do_read(4'd2, 4'd3, 1, 3, 1'b0);

        q_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_write(4'd14, 4'd3, q_data, q_gaps);
        do_read(4'd14, 4'd3, -1, 0, 1'b0);

        q_data = '{8'h5A, 8'hC3};
        q_gaps = '{1, 2};
        do_write(4'd7, 4'd1, q_data, q_gaps);
        do_read(4'd6, 4'd2, -1, 0, 1'b0);

        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_adr = 4'd2; cmd_len = 4'd15;
        @(negedge clk);
        chk("abort_cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_data = 8'hE0 + 8'(i);
            @(negedge clk);
            chk("abort_we", we, 1);
            step();
            shadow[4'd2 + 4'(i)] = 8'hE0 + 8'(i);
        end
        rst = 1'b1; wr_valid = 1'b1; wr_data = 8'hFF;
        @(negedge clk);
        chk("abort_rst_we", we, 0);
        chk("abort_rst_busy", busy, 0);
        chk("abort_rst_cmd_ready", cmd_ready, 0);
        step();
        rst = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        chk("abort_we_after", we, 0);
        chk("abort_busy_after", busy, 0);
        chk("abort_done_after", done, 0);
        chk("abort_cmd_ready_after", cmd_ready, 1);
        step();
        do_read(4'd2, 4'd2, -1, 0, 1'b0);

        repeat (8) begin
            ra = 4'($urandom);
            rl = 4'($urandom);
            q_data = {};
            q_gaps = {};
            for (int i = 0; i <= int'(rl); i++) begin
                q_data.push_back(8'($urandom));
                q_gaps.push_back(int'($urandom_range(0, 2)));
            end
            do_write(ra, rl, q_data, q_gaps);
            do_read(ra, rl, -1, 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
